// File: rtl/vscale_mul_div_pkg.sv
// Shared constants for the vscale multiply/divide unit.
//   - default operand width
//   - operation encodings carried on req_op
//   - FSM state encodings
//   - helpers that decode which operands an operation treats as signed
package vscale_mul_div_pkg;

  localparam int unsigned XPR_LEN_DEFAULT = 32;
  localparam int unsigned MD_OP_W         = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MdOpMul    = 3'd0,
    MdOpMulh   = 3'd1,
    MdOpMulhsu = 3'd2,
    MdOpMulhu  = 3'd3,
    MdOpDiv    = 3'd4,
    MdOpDivu   = 3'd5,
    MdOpRem    = 3'd6,
    MdOpRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StCompute = 2'd2,
    StDone    = 2'd3
  } md_state_e;

  // MUL is treated as signed x signed; its low half is the same either way.
  function automatic logic op_in1_signed(input md_op_e op);
    return op inside {MdOpMul, MdOpMulh, MdOpMulhsu, MdOpDiv, MdOpRem};
  endfunction

  function automatic logic op_in2_signed(input md_op_e op);
    return op inside {MdOpMul, MdOpMulh, MdOpDiv, MdOpRem};
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/vscale_mul_div.sv
// Iterative multiply/divide unit: one radix-2 step per cycle.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_op, req_in1, req_in2 operation and operands
//   kill                     abort the in-flight operation (ignored when idle)
//   resp_valid/resp_ready    response handshake
//   resp_result              result, held stable while resp_valid is high
// Datapath: acc_q is a 2*XPR_LEN+1 accumulator (product, or remainder:quotient),
// opnd_q holds the multiplicand/divisor magnitude, counter_q counts steps.
module vscale_mul_div
  import vscale_mul_div_pkg::*;
#(
  parameter int unsigned XPR_LEN = XPR_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MD_OP_W-1:0] req_op,
  input  logic [XPR_LEN-1:0] req_in1,
  input  logic [XPR_LEN-1:0] req_in2,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_result
);

  localparam int unsigned N  = XPR_LEN;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  md_state_e       state_q;
  md_op_e          op_q;
  logic [2*N:0]    acc_q;
  logic [N-1:0]    opnd_q;
  logic [N-1:0]    result_q;
  logic [CW-1:0]   counter_q;
  logic            neg_q;

  // Setup-phase decode: magnitudes and output sign correction.
  logic            s1, s2, div_zero, neg_d;
  logic [N-1:0]    mag1, mag2;

  always_comb begin
    s1       = op_in1_signed(op_q) & acc_q[N-1];
    s2       = op_in2_signed(op_q) & opnd_q[N-1];
    mag1     = s1 ? -acc_q[N-1:0] : acc_q[N-1:0];
    mag2     = s2 ? -opnd_q : opnd_q;
    div_zero = (opnd_q == '0);
    neg_d    = s1 ^ s2;
    case (op_q)
      // Divide by zero returns all-ones with no sign fix-up.
      MdOpDiv:            neg_d = (s1 ^ s2) & ~div_zero;
      MdOpRem:            neg_d = s1;
      MdOpDivu, MdOpRemu: neg_d = 1'b0;
      default:            ;
    endcase
  end

  // One iteration step.
  logic [N:0]      mul_sum;
  logic [N:0]      rem_sh, rem_diff;
  logic            rem_ge;
  logic [2*N:0]    step_next;

  always_comb begin
    // Shift-add: high half accumulates, multiplier bits consumed from bit 0.
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? opnd_q : {N{1'b0}})};
    // Restoring divide: shift next dividend bit into remainder, try subtract.
    rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    if (op_is_div(op_q)) begin
      step_next = {(rem_ge ? rem_diff : rem_sh), acc_q[N-2:0], rem_ge};
    end else begin
      step_next = {1'b0, mul_sum, acc_q[N-1:1]};
    end
  end

  // Final result, formed from the value the last step produces.
  logic [2*N-1:0]  prod, prod_fix;
  logic [N-1:0]    quo, rem, result_d;

  always_comb begin
    prod     = step_next[2*N-1:0];
    prod_fix = neg_q ? -prod : prod;
    quo      = step_next[N-1:0];
    rem      = step_next[2*N-1:N];
    result_d = prod_fix[N-1:0];
    unique case (op_q)
      MdOpMul:                        result_d = prod_fix[N-1:0];
      MdOpMulh, MdOpMulhsu, MdOpMulhu: result_d = prod_fix[2*N-1:N];
      MdOpDiv, MdOpDivu:              result_d = neg_q ? -quo : quo;
      MdOpRem, MdOpRemu:              result_d = neg_q ? -rem : rem;
    endcase
  end

  // Top accumulator bit is a carry slot that never needs to be read back.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_q[2*N] ^ step_next[2*N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= MdOpMul;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      counter_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= md_op_e'(req_op);
            acc_q   <= {{(N+1){1'b0}}, req_in1};
            opnd_q  <= req_in2;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            acc_q     <= {{(N+1){1'b0}}, mag1};
            opnd_q    <= mag2;
            neg_q     <= neg_d;
            counter_q <= '0;
            state_q   <= StCompute;
          end
        end
        StCompute: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            acc_q     <= step_next;
            counter_q <= counter_q + CW'(1);
            if (counter_q == CW'(N-1)) begin
              result_q <= result_d;
              state_q  <= StDone;
            end
          end
        end
        StDone: begin
          if (kill || resp_ready) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StDone);
  assign resp_result = result_q;

endmodule
